// File: rtl/fe_pc_ctl_pkg.sv
// fe_pc_ctl_pkg
//   Shared types for the front-end fetch sequencer: physical address and
//   instruction packets, redirect packets, FSM state, perf counter bundle.
//   FE_OUTST_W matches the default MAX_OUTSTANDING of fe_pc_ctl.
package fe_pc_ctl_pkg;

  localparam int PADDR_W            = 32;
  localparam int INSTR_W            = 32;
  localparam int FE_MAX_OUTSTANDING = 4;
  localparam int FE_OUTST_W         = $clog2(FE_MAX_OUTSTANDING + 1);

  typedef logic [PADDR_W-1:0] t_paddr;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
  } t_instr_pkt;

  typedef struct packed {
    logic   valid;
    t_paddr restore_pc;
  } t_br_mispred_pkt;

  typedef struct packed {
    logic   valid;
    t_paddr restore_pc;
  } t_nuke_pkt;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } t_fe_pc_state;

  typedef struct packed {
    logic [31:0] redirects;
    logic [31:0] stale_drops;
    logic [31:0] credit_stall_cycles;
  } t_fe_perf;

  // Saturating increment for the perf counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fe_stale_tracker.sv
// fe_stale_tracker
//   Counts icache requests in flight and how many of them were orphaned by a
//   redirect, and decides whether the current response goes to decode.
// Ports
//   clk, reset_n    clock, synchronous active-low reset
//   i_fire          request accepted by icache this cycle
//   i_rsp           icache response this cycle (in request order)
//   i_redirect      redirect taken this cycle
//   o_rsp_ok        response is live (not stale, no same-cycle redirect)
//   o_credit_ok     outst_cnt < MAX_OUTSTANDING (registered count only)
//   o_outst_cnt     requests in flight
//   o_stale_cnt     in-flight requests whose responses must be dropped
module fe_stale_tracker #(
  parameter int MAX_OUTSTANDING = 4,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_fire,
  input  logic          i_rsp,
  input  logic          i_redirect,
  output logic          o_rsp_ok,
  output logic          o_credit_ok,
  output logic [OW-1:0] o_outst_cnt,
  output logic [OW-1:0] o_stale_cnt
);

  logic [OW-1:0] r_outst_cnt;
  logic [OW-1:0] r_stale_cnt;
  logic [OW:0]   w_total;
  logic [OW-1:0] w_stale_nxt;

  // One extra bit so the +fire-rsp arithmetic cannot alias; fire is only
  // possible below MAX, so the result always fits back into OW bits.
  assign w_total = {1'b0, r_outst_cnt} + (OW+1)'(i_fire) - (OW+1)'(i_rsp);

  // A redirect orphans everything still in flight, including a request
  // accepted this very cycle.
  always_comb begin
    w_stale_nxt = r_stale_cnt;
    if (i_redirect)
      w_stale_nxt = w_total[OW-1:0];
    else if (i_rsp && (r_stale_cnt != '0))
      w_stale_nxt = r_stale_cnt - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_outst_cnt <= '0;
      r_stale_cnt <= '0;
    end else begin
      r_outst_cnt <= w_total[OW-1:0];
      r_stale_cnt <= w_stale_nxt;
    end
  end

  assign o_rsp_ok    = i_rsp && (r_stale_cnt == '0) && !i_redirect;
  assign o_credit_ok = r_outst_cnt < OW'(MAX_OUTSTANDING);
  assign o_outst_cnt = r_outst_cnt;
  assign o_stale_cnt = r_stale_cnt;

`ifdef ASSERT
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (r_outst_cnt <= OW'(MAX_OUTSTANDING)) else $error("outst_cnt above limit");
      assert (r_stale_cnt <= r_outst_cnt) else $error("stale_cnt above outst_cnt");
      assert (!(i_rsp && (r_outst_cnt == '0))) else $error("rsp with nothing outstanding");
    end
  end
`endif

endmodule

// File: rtl/fe_pc_ctl.sv
// fe_pc_ctl
//   Front-end fetch sequencer. Owns the fetch PC, issues in-order requests to
//   the icache under a credit limit, arbitrates redirects (nuke over branch
//   mispredict over sequential), and drops stale responses after a redirect.
// Ports
//   clk, reset_n       clock, synchronous active-low reset
//   decode_ready_de0   decode has room; gates new requests
//   br_mispred_ex0     branch redirect {valid, restore_pc}
//   nuke_rb1           nuke redirect {valid, restore_pc}, wins over branch
//   ic_req_valid/ready/pc  fetch request handshake
//   ic_rsp_valid/instr in-order icache response
//   valid_fe1/instr_fe1    live response toward decode
//   redirect_fe0       redirect taken this cycle (combinational)
//   perf_fe_pc         perf counters, present only with FE_PC_CTL_PERF_EN
// Configuration
//   FE_PC_CTL_PERF_EN  adds saturating redirect/stale-drop/credit-stall counters
module fe_pc_ctl
  import fe_pc_ctl_pkg::*;
#(
  parameter t_paddr RESET_PC        = 32'h0000_0000,
  parameter int     MAX_OUTSTANDING = 4,
  parameter int     FETCH_BYTES     = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            decode_ready_de0,
  input  t_br_mispred_pkt br_mispred_ex0,
  input  t_nuke_pkt       nuke_rb1,
  output logic            ic_req_valid,
  input  logic            ic_req_ready,
  output t_paddr          ic_req_pc,
  input  logic            ic_rsp_valid,
  input  t_instr_pkt      ic_rsp_instr,
  output logic            valid_fe1,
  output t_instr_pkt      instr_fe1,
  output logic            redirect_fe0
`ifdef FE_PC_CTL_PERF_EN
  ,
  output t_fe_perf        perf_fe_pc
`endif
);

  localparam int OUTST_W = $clog2(MAX_OUTSTANDING + 1);

  t_fe_pc_state r_state, w_state_nxt;
  t_paddr       r_pc, w_pc_nxt;
  t_paddr       w_restore_pc;
  logic         w_redirect;
  logic         w_fire;
  logic         w_credit_ok;
  logic         w_rsp_ok;
  logic [OUTST_W-1:0] w_outst_cnt;
  logic [OUTST_W-1:0] w_stale_cnt;

  assign w_redirect   = nuke_rb1.valid | br_mispred_ex0.valid;
  assign w_restore_pc = nuke_rb1.valid ? nuke_rb1.restore_pc : br_mispred_ex0.restore_pc;

  // Redirect suppresses the request the same cycle, so a redirect never
  // coincides with a fire and the held PC can be replaced safely.
  assign ic_req_valid = (r_state == RUN) && decode_ready_de0 && w_credit_ok && !w_redirect;
  assign w_fire       = ic_req_valid && ic_req_ready;
  assign ic_req_pc    = r_pc;
  assign redirect_fe0 = w_redirect;
  assign valid_fe1    = w_rsp_ok;
  assign instr_fe1    = ic_rsp_instr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_redirect ? BUBBLE : RUN;
      RUN:     w_state_nxt = w_redirect ? BUBBLE : RUN;
      BUBBLE:  w_state_nxt = w_redirect ? BUBBLE : RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sequential increment wraps modulo 2^PADDR_W by plain truncation.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_redirect)
      w_pc_nxt = w_restore_pc;
    else if (w_fire)
      w_pc_nxt = r_pc + PADDR_W'(FETCH_BYTES);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  fe_stale_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_trk (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_fire      (w_fire),
    .i_rsp       (ic_rsp_valid),
    .i_redirect  (w_redirect),
    .o_rsp_ok    (w_rsp_ok),
    .o_credit_ok (w_credit_ok),
    .o_outst_cnt (w_outst_cnt),
    .o_stale_cnt (w_stale_cnt)
  );

`ifdef FE_PC_CTL_PERF_EN
  t_fe_perf r_perf;
  logic     w_credit_stall;

  assign w_credit_stall = decode_ready_de0 && (w_outst_cnt == OUTST_W'(MAX_OUTSTANDING));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf <= '0;
    end else begin
      r_perf.redirects           <= sat_inc(r_perf.redirects, w_redirect);
      r_perf.stale_drops         <= sat_inc(r_perf.stale_drops, ic_rsp_valid && !w_rsp_ok);
      r_perf.credit_stall_cycles <= sat_inc(r_perf.credit_stall_cycles, w_credit_stall);
    end
  end

  assign perf_fe_pc = r_perf;
`endif

`ifdef ASSERT
  logic   r_a_hold;
  t_paddr r_a_pc;

  // A request left pending by the icache must reappear with the same PC.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a_hold <= 1'b0;
      r_a_pc   <= '0;
    end else begin
      r_a_hold <= ic_req_valid && !ic_req_ready;
      r_a_pc   <= ic_req_pc;
      if (r_a_hold && ic_req_valid)
        assert (ic_req_pc == r_a_pc) else $error("ic_req_pc changed while stalled");
    end
  end
`endif

  logic w_unused;
  assign w_unused = ^w_stale_cnt;

endmodule

// File: tb/tb_fe_pc_ctl.sv
module tb_fe_pc_ctl;
  import fe_pc_ctl_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            decode_ready_de0;
  t_br_mispred_pkt br_mispred_ex0;
  t_nuke_pkt       nuke_rb1;
  logic            ic_req_valid;
  logic            ic_req_ready;
  t_paddr          ic_req_pc;
  logic            ic_rsp_valid;
  t_instr_pkt      ic_rsp_instr;
  logic            valid_fe1;
  t_instr_pkt      instr_fe1;
  logic            redirect_fe0;
`ifdef FE_PC_CTL_PERF_EN
  t_fe_perf        perf_fe_pc;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fe_pc_ctl u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .decode_ready_de0 (decode_ready_de0),
    .br_mispred_ex0   (br_mispred_ex0),
    .nuke_rb1         (nuke_rb1),
    .ic_req_valid     (ic_req_valid),
    .ic_req_ready     (ic_req_ready),
    .ic_req_pc        (ic_req_pc),
    .ic_rsp_valid     (ic_rsp_valid),
    .ic_rsp_instr     (ic_rsp_instr),
    .valid_fe1        (valid_fe1),
    .instr_fe1        (instr_fe1),
    .redirect_fe0     (redirect_fe0)
`ifdef FE_PC_CTL_PERF_EN
    ,
    .perf_fe_pc       (perf_fe_pc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge; inputs are then driven and outputs
  // sampled #1 later, well clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; decode_ready_de0 = 1'b0; ic_req_ready = 1'b0;
    ic_rsp_valid = 1'b0; ic_rsp_instr = '0;
    br_mispred_ex0 = '0; nuke_rb1 = '0;

    // 1: reset state, then four sequential requests.
    repeat (3) tick();
    #1;
    chk("rst_state", 32'(u_dut.r_state), 32'(IDLE));
    chk("rst_pc", ic_req_pc, 32'h0);
    chk("rst_req_valid", 32'(ic_req_valid), 32'h0);
    chk("rst_valid_fe1", 32'(valid_fe1), 32'h0);
    chk("rst_redirect", 32'(redirect_fe0), 32'h0);
    chk("rst_outst", 32'(u_dut.w_outst_cnt), 32'h0);
    chk("rst_stale", 32'(u_dut.w_stale_cnt), 32'h0);

    reset_n = 1'b1; decode_ready_de0 = 1'b1; ic_req_ready = 1'b1;
    #1;
    chk("idle_no_req", 32'(ic_req_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("seq_valid", 32'(ic_req_valid), 32'h1);
      chk("seq_pc", ic_req_pc, 32'(i * 4));
    end

    // 2: credit limit with icache stalled.
    tick(); ic_req_ready = 1'b0; #1;
    chk("credit_outst4", 32'(u_dut.w_outst_cnt), 32'd4);
    chk("credit_no_req", 32'(ic_req_valid), 32'h0);
    chk("credit_pc", ic_req_pc, 32'h10);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("stall_no_req", 32'(ic_req_valid), 32'h0);
      chk("stall_pc", ic_req_pc, 32'h10);
    end
    tick(); ic_rsp_valid = 1'b1; ic_rsp_instr.instr = 32'hA000_0000; #1;
    chk("rsp0_valid_fe1", 32'(valid_fe1), 32'h1);
    chk("rsp0_instr", instr_fe1.instr, 32'hA000_0000);
    chk("rsp0_credit_not_freed", 32'(ic_req_valid), 32'h0);
    tick(); ic_rsp_valid = 1'b0; #1;
    chk("resume_valid", 32'(ic_req_valid), 32'h1);
    chk("resume_pc", ic_req_pc, 32'h10);
    for (int k = 1; k < 4; k++) begin
      tick(); ic_rsp_valid = 1'b1; ic_rsp_instr.instr = 32'hA000_0000 + 32'(k); #1;
      chk("rsp_valid_fe1", 32'(valid_fe1), 32'h1);
      chk("rsp_instr", instr_fe1.instr, 32'hA000_0000 + 32'(k));
      chk("held_pc", ic_req_pc, 32'h10);
    end
    tick(); ic_rsp_valid = 1'b0; #1;
    chk("drain_outst", 32'(u_dut.w_outst_cnt), 32'h0);

    // 3: three in flight, branch mispredict to 0x100.
    ic_req_ready = 1'b1;
    repeat (3) tick();
    #1;
    chk("pre_mp_pc", ic_req_pc, 32'h1C);
    br_mispred_ex0 = '{valid: 1'b1, restore_pc: 32'h100}; #1;
    chk("mp_redirect", 32'(redirect_fe0), 32'h1);
    chk("mp_no_req", 32'(ic_req_valid), 32'h0);
    chk("mp_outst", 32'(u_dut.w_outst_cnt), 32'd3);
    tick(); br_mispred_ex0 = '0; ic_rsp_valid = 1'b1; ic_rsp_instr.instr = 32'hB000_0001; #1;
    chk("mp_bubble", 32'(u_dut.r_state), 32'(BUBBLE));
    chk("mp_stale3", 32'(u_dut.w_stale_cnt), 32'd3);
    chk("mp_bubble_no_req", 32'(ic_req_valid), 32'h0);
    chk("mp_drop1", 32'(valid_fe1), 32'h0);
    tick(); #1;
    chk("mp_req_valid", 32'(ic_req_valid), 32'h1);
    chk("mp_req_pc", ic_req_pc, 32'h100);
    chk("mp_drop2", 32'(valid_fe1), 32'h0);
    tick(); ic_req_ready = 1'b0; #1;
    chk("mp_drop3", 32'(valid_fe1), 32'h0);
    tick(); ic_rsp_instr.instr = 32'hC000_0100; #1;
    chk("mp_live", 32'(valid_fe1), 32'h1);
    chk("mp_live_instr", instr_fe1.instr, 32'hC000_0100);
    chk("mp_stale0", 32'(u_dut.w_stale_cnt), 32'h0);
    tick(); ic_rsp_valid = 1'b0; #1;
    chk("mp_outst0", 32'(u_dut.w_outst_cnt), 32'h0);

    // 4: nuke and mispredict together, nuke wins.
    nuke_rb1 = '{valid: 1'b1, restore_pc: 32'h200};
    br_mispred_ex0 = '{valid: 1'b1, restore_pc: 32'h300}; #1;
    chk("both_redirect", 32'(redirect_fe0), 32'h1);
    tick(); nuke_rb1 = '0; br_mispred_ex0 = '0; #1;
    chk("both_bubble_no_req", 32'(ic_req_valid), 32'h0);
    tick(); ic_req_ready = 1'b1; #1;
    chk("nuke_wins_pc", ic_req_pc, 32'h200);
    chk("nuke_wins_valid", 32'(ic_req_valid), 32'h1);
    tick(); #1;
    chk("post_nuke_pc", ic_req_pc, 32'h204);

    // 5: redirect in the same cycle as a response, two in flight.
    tick();
    ic_rsp_valid = 1'b1; ic_rsp_instr.instr = 32'hD000_0200;
    br_mispred_ex0 = '{valid: 1'b1, restore_pc: 32'h400}; #1;
    chk("same_redirect", 32'(redirect_fe0), 32'h1);
    chk("same_no_req", 32'(ic_req_valid), 32'h0);
    chk("same_rsp_dropped", 32'(valid_fe1), 32'h0);
    tick(); br_mispred_ex0 = '0; ic_rsp_instr.instr = 32'hD000_0204; #1;
    chk("same_outst1", 32'(u_dut.w_outst_cnt), 32'd1);
    chk("same_stale1", 32'(u_dut.w_stale_cnt), 32'd1);
    chk("same_bubble_drop", 32'(valid_fe1), 32'h0);
    tick(); ic_rsp_valid = 1'b0; ic_req_ready = 1'b0; #1;
    chk("same_outst0", 32'(u_dut.w_outst_cnt), 32'h0);
    chk("same_stale0", 32'(u_dut.w_stale_cnt), 32'h0);
    chk("same_req_pc", ic_req_pc, 32'h400);
    chk("same_req_valid", 32'(ic_req_valid), 32'h1);
`ifdef FE_PC_CTL_PERF_EN
    chk("perf_redirects", perf_fe_pc.redirects, 32'd3);
    chk("perf_stale_drops", perf_fe_pc.stale_drops, 32'd5);
    chk("perf_credit_stall", perf_fe_pc.credit_stall_cycles, 32'd4);
`endif

    // 6: PC wrap at the top of the address space, then mid-stream reset.
    nuke_rb1 = '{valid: 1'b1, restore_pc: 32'hFFFF_FFF8}; #1;
    tick(); nuke_rb1 = '0; ic_req_ready = 1'b1; #1;
    chk("wrap_bubble", 32'(ic_req_valid), 32'h0);
    tick(); #1;
    chk("wrap_pc0", ic_req_pc, 32'hFFFF_FFF8);
    tick(); #1;
    chk("wrap_pc1", ic_req_pc, 32'hFFFF_FFFC);
    tick(); ic_req_ready = 1'b0; #1;
    chk("wrap_pc2", ic_req_pc, 32'h0000_0000);
    chk("wrap_outst2", 32'(u_dut.w_outst_cnt), 32'd2);
    reset_n = 1'b0;
    tick(); #1;
    chk("mid_rst_state", 32'(u_dut.r_state), 32'(IDLE));
    chk("mid_rst_pc", ic_req_pc, 32'h0);
    chk("mid_rst_outst", 32'(u_dut.w_outst_cnt), 32'h0);
    chk("mid_rst_stale", 32'(u_dut.w_stale_cnt), 32'h0);
    chk("mid_rst_req", 32'(ic_req_valid), 32'h0);
`ifdef FE_PC_CTL_PERF_EN
    chk("mid_rst_perf", perf_fe_pc.redirects, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
